latch_serializer: RTL and testbench

LATCH_SERIALIZER -- requirements
Module: latch_serializer

---
 rtl/latch_serializer_if.sv | 26 ++
 rtl/latch_serializer.sv | 139 +++++++++++++
 tb/tb_latch_serializer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/latch_serializer_if.sv
// Handshake bundle between a frame requester/word source and the latch serializer.
// slave is the serializer side; master is the side that drives start, word and FIFO status.
interface latch_serializer_if #(
    parameter int NB      = 8,
    parameter int NB_DATA = 32,
    parameter int NB_SEL  = 4
);
    logic               i_start;
    logic [NB_DATA-1:0] i_word;
    logic               i_tx_full;
    logic [NB_SEL-1:0]  o_word_sel;
    logic [NB-1:0]      o_tx_data;
    logic               o_wr_uart;
    logic               o_busy;
    logic               o_done;

    modport slave (
        input  i_start, i_word, i_tx_full,
        output o_word_sel, o_tx_data, o_wr_uart, o_busy, o_done
    );

    modport master (
        output i_start, i_word, i_tx_full,
        input  o_word_sel, o_tx_data, o_wr_uart, o_busy, o_done
    );
endinterface

// File: rtl/latch_serializer.sv
// Streams a frame of HEADER, N_WORDS latched words (MSB byte first) and an XOR checksum
// into a UART TX FIFO, stalling on the FIFO full flag.
//
// state    | meaning
// IDLE     | waiting for i_start
// HEADER   | writing the frame start byte
// FETCH    | latching the word addressed by o_word_sel
// SEND     | shifting out the latched word one byte per accepted write
// CHECKSUM | writing the running XOR of every byte sent
// DONE     | one-cycle completion pulse
module latch_serializer #(
    parameter int          NB      = 8,
    parameter int          NB_DATA = 32,
    parameter int          N_WORDS = 16,
    parameter int          NB_SEL  = 4,
    parameter logic [NB-1:0] HEADER = 8'hA5
) (
    input  logic i_clk,
    input  logic i_reset,
    latch_serializer_if.slave bus
);
    localparam int BPW   = NB_DATA / NB;
    localparam int NB_BC = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_FETCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_CHECKSUM = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NB_SEL-1:0]  word_cnt;
    logic [NB_BC-1:0]   byte_cnt;
    logic [NB_DATA-1:0] word_buf;
    logic [NB-1:0]      chk;
    logic               wr;
    logic [NB-1:0]      tx_data;
    logic               last_byte;
    logic               last_word;

    assign last_byte = (byte_cnt == NB_BC'(BPW - 1));
    assign last_word = (word_cnt == NB_SEL'(N_WORDS - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr         = 1'b0;
        tx_data    = '0;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) state_next = ST_HEADER;
            end
            ST_HEADER: begin
                tx_data = HEADER;
                if (!bus.i_tx_full) begin
                    wr         = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                tx_data = word_buf[NB_DATA-1 -: NB];
                if (!bus.i_tx_full) begin
                    wr = 1'b1;
                    if (last_byte) state_next = last_word ? ST_CHECKSUM : ST_FETCH;
                end
            end
            ST_CHECKSUM: begin
                tx_data = chk;
                if (!bus.i_tx_full) begin
                    wr         = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counters stop at their last value instead of wrapping; FETCH and DONE reload them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            chk      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        chk      <= '0;
                    end
                end
                ST_HEADER: begin
                    if (wr) chk <= HEADER;
                end
                ST_FETCH: begin
                    word_buf <= bus.i_word;
                    byte_cnt <= '0;
                end
                ST_SEND: begin
                    if (wr) begin
                        word_buf <= word_buf << NB;
                        chk      <= chk ^ word_buf[NB_DATA-1 -: NB];
                        if (!last_byte)      byte_cnt <= byte_cnt + NB_BC'(1);
                        else if (!last_word) word_cnt <= word_cnt + NB_SEL'(1);
                    end
                end
                ST_DONE: begin
                    word_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Reset masks the outputs in the same cycle so an aborted frame never writes again.
    assign bus.o_wr_uart  = wr & ~i_reset;
    assign bus.o_tx_data  = i_reset ? '0 : tx_data;
    assign bus.o_word_sel = i_reset ? '0 : word_cnt;
    assign bus.o_busy     = (state != ST_IDLE) & ~i_reset;
    assign bus.o_done     = (state == ST_DONE) & ~i_reset;
endmodule

// File: tb/tb_latch_serializer.sv
// Randomized scoreboard bench for latch_serializer: the driver queues the expected byte
// stream and done time for each frame, a negedge monitor pops and compares.
module tb_latch_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    latch_serializer_if #(.NB(8), .NB_DATA(32), .NB_SEL(4)) bus0 ();
    latch_serializer_if #(.NB(8), .NB_DATA(32), .NB_SEL(4)) bus1 ();

    logic [31:0] mem [16];
    assign bus0.i_word = mem[bus0.o_word_sel];
    assign bus1.i_word = 32'h0;

    latch_serializer #(.N_WORDS(2)) dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
    latch_serializer #(.N_WORDS(1)) dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;

    exp_t exp_q [$];
    int   done_q [$];
    int   wr_count = 0;
    exp_t mon_e;
    int   mon_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference frame: header, each word MSB byte first, then XOR of everything.
    // Timing (no stall): header at +1, word w byte b at +3+5w+b, checksum at +2+5N.
    task automatic build_frame(input int c0, input bit timed, input int shift);
        logic [7:0] x;
        logic [7:0] byt;
        exp_t e;
        x = 8'hA5;
        e.b = 8'hA5; e.c = timed ? c0 + 1 + shift : -1;
        exp_q.push_back(e);
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++) begin
                byt = 8'(mem[w] >> (8 * (3 - b)));
                x   = x ^ byt;
                e.b = byt; e.c = timed ? c0 + 3 + 5 * w + b + shift : -1;
                exp_q.push_back(e);
            end
        end
        e.b = x; e.c = timed ? c0 + 2 + 5 * 2 + shift : -1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus0.o_wr_uart) begin
            wr_count++;
            check("wr_while_full", 64'(bus0.i_tx_full), 64'd0);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", bus0.o_tx_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_byte", 64'(bus0.o_tx_data), 64'(mon_e.b));
                if (mon_e.c >= 0) check("byte_cycle", 64'(cyc), 64'(mon_e.c));
            end
        end
        if (bus0.o_done) begin
            if (done_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_d = done_q.pop_front();
                check("done_bytes_left", 64'(exp_q.size()), 64'd0);
                if (mon_d >= 0) check("done_cycle", 64'(cyc), 64'(mon_d));
            end
        end
    end

    // mode 0: no stall; 1: random full; 2: full for 5 cycles on third data byte;
    // 3: full when start arrives, released after 4 cycles.
    task automatic run_frame(input int mode, input bit extra_start);
        int c0;
        bit ok;
        c0 = cyc;
        ok = 1'b0;
        case (mode)
            0: begin build_frame(c0, 1'b1, 0); done_q.push_back(c0 + 13); end
            2: begin build_frame(c0, 1'b0, 0); done_q.push_back(c0 + 18); end
            3: begin build_frame(c0, 1'b1, 4); done_q.push_back(c0 + 17); end
            default: begin build_frame(c0, 1'b0, 0); done_q.push_back(-1); end
        endcase
        bus0.i_start   = 1'b1;
        bus0.i_tx_full = (mode == 3);
        for (int k = 1; k < 400; k++) begin
            @(posedge clk); #1;
            bus0.i_start = extra_start && (k == 3 || $urandom_range(0, 3) == 0);
            case (mode)
                1: bus0.i_tx_full = ($urandom_range(0, 2) == 0);
                2: bus0.i_tx_full = (k >= 5 && k <= 9);
                3: bus0.i_tx_full = (k <= 4);
                default: bus0.i_tx_full = 1'b0;
            endcase
            @(negedge clk);
            if (k == 1) check("busy_in_frame", 64'(bus0.o_busy), 64'd1);
            if (mode == 3 && k == 5) begin
                check("header_on_release_wr", 64'(bus0.o_wr_uart), 64'd1);
                check("header_on_release_data", 64'(bus0.o_tx_data), 64'hA5);
            end
            if (bus0.o_done) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL frame_timeout: got no o_done expected o_done (cycle %0d)", cyc);
        end
        @(posedge clk); #1;
        bus0.i_start   = 1'b0;
        bus0.i_tx_full = 1'b0;
        @(negedge clk);
        check("busy_after_frame", 64'(bus0.o_busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_frame();
        int c0;
        int base;
        bit ok;
        c0   = cyc;
        base = wr_count;
        ok   = 1'b0;
        build_frame(c0, 1'b1, 0);
        done_q.push_back(c0 + 13);
        bus0.i_start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            bus0.i_start = 1'b0;
            if (wr_count - base >= 6) begin ok = 1'b1; break; end
        end
        check("six_bytes_before_reset", 64'(ok), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        check("abort_wr", 64'(bus0.o_wr_uart), 64'd0);
        check("abort_busy", 64'(bus0.o_busy), 64'd0);
        check("abort_word_sel", 64'(bus0.o_word_sel), 64'd0);
        check("abort_tx_data", 64'(bus0.o_tx_data), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_held_busy", 64'(bus0.o_busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(0, 1'b0);
    endtask

    task automatic single_word_frame();
        logic [7:0] got [8];
        logic [7:0] req [6];
        int n;
        int done_k;
        n      = 0;
        done_k = -1;
        req    = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        bus1.i_start = 1'b1;
        for (int k = 1; k < 30; k++) begin
            @(posedge clk); #1;
            bus1.i_start = 1'b0;
            @(negedge clk);
            check("n1_word_sel", 64'(bus1.o_word_sel), 64'd0);
            if (bus1.o_wr_uart && n < 8) begin got[n] = bus1.o_tx_data; n++; end
            if (bus1.o_done) begin done_k = k; break; end
        end
        check("n1_done_cycle", 64'(done_k), 64'd8);
        check("n1_byte_count", 64'(n), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < n) check("n1_byte", 64'(got[i]), 64'(req[i]));
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst            = 1'b1;
        bus0.i_start   = 1'b0;
        bus0.i_tx_full = 1'b0;
        bus1.i_start   = 1'b0;
        bus1.i_tx_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", 64'(bus0.o_busy), 64'd0);
        check("rst_wr", 64'(bus0.o_wr_uart), 64'd0);
        check("rst_done", 64'(bus0.o_done), 64'd0);
        check("rst_word_sel", 64'(bus0.o_word_sel), 64'd0);
        check("rst_tx_data", 64'(bus0.o_tx_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        run_frame(0, 1'b0);
        run_frame(2, 1'b0);
        run_frame(0, 1'b1);
        reset_mid_frame();
        run_frame(3, 1'b0);

        for (int f = 0; f < 10; f++) begin
            mem[0] = $urandom;
            mem[1] = $urandom;
            run_frame(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        single_word_frame();

        check("queue_drained", 64'(exp_q.size() + done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
